// File: rtl/vga_plot_arbiter_if.sv
// Signal bundle between the pixel requesters / clear control and the arbiter,
// including the arbiter's write port toward vga_adapter.
interface vga_plot_arbiter_if;
    logic       clear_start;
    logic [2:0] clear_colour;
    logic       clear_busy;
    logic       clear_done;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req0_x;
    logic [6:0] req0_y;
    logic [2:0] req0_colour;
    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] req1_x;
    logic [6:0] req1_y;
    logic [2:0] req1_colour;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport slave (
        input  clear_start, clear_colour,
        input  req0_valid, req0_x, req0_y, req0_colour,
        input  req1_valid, req1_x, req1_y, req1_colour,
        output clear_busy, clear_done, req0_ready, req1_ready,
        output vga_x, vga_y, vga_colour, vga_plot
    );

    modport master (
        output clear_start, clear_colour,
        output req0_valid, req0_x, req0_y, req0_colour,
        output req1_valid, req1_x, req1_y, req1_colour,
        input  clear_busy, clear_done, req0_ready, req1_ready,
        input  vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter for two pixel requesters in front of vga_adapter, with a
// built-in clear-screen sweep that has priority and writes one pixel per cycle.
module vga_plot_arbiter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                clock,
    input  logic                resetn,
    vga_plot_arbiter_if.slave   bus
);
    localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);
    localparam logic [8:0] X_LIM  = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIM  = 8'(SCREEN_H);

    typedef enum logic {ST_ARB = 1'b0, ST_CLEAR = 1'b1} state_e;

    state_e     state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] cx_q, cx_d;
    logic [6:0] cy_q, cy_d;
    logic [2:0] clr_colour_q, clr_colour_d;
    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] vga_colour_q, vga_colour_d;
    logic       vga_plot_q, vga_plot_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       grant0_s, grant1_s, sweep_s, at_last_s;

    function automatic logic in_range(input logic [7:0] x, input logic [6:0] y);
        return ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
    endfunction

    assign at_last_s = (cx_q == X_LAST) && (cy_q == Y_LAST);

    // Next-state: clear sweep (counters idle at 0 in ARB, so the first pixel
    // goes out in the clear_start cycle itself), else round-robin grant.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        clr_colour_d = clr_colour_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        grant0_s     = 1'b0;
        grant1_s     = 1'b0;
        sweep_s      = 1'b0;

        case (state_q)
            ST_ARB: begin
                if (bus.clear_start) begin
                    sweep_s      = 1'b1;
                    clr_colour_d = bus.clear_colour;
                end else begin
                    grant0_s = bus.req0_valid && (!bus.req1_valid || last_grant_q);
                    grant1_s = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
                end
            end
            ST_CLEAR: sweep_s = 1'b1;
            default:  state_d = ST_ARB;
        endcase

        if (sweep_s) begin
            vga_x_d      = cx_q;
            vga_y_d      = cy_q;
            vga_colour_d = (state_q == ST_CLEAR) ? clr_colour_q : bus.clear_colour;
            vga_plot_d   = 1'b1;
            busy_d       = 1'b1;
            if (at_last_s) begin
                done_d  = 1'b1;
                state_d = ST_ARB;
                cx_d    = 8'd0;
                cy_d    = 7'd0;
            end else begin
                state_d = ST_CLEAR;
                if (cx_q == X_LAST) begin
                    cx_d = 8'd0;
                    cy_d = cy_q + 7'd1;
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
        end else if (grant0_s) begin
            last_grant_d = 1'b0;
            if (in_range(bus.req0_x, bus.req0_y)) begin
                vga_x_d      = bus.req0_x;
                vga_y_d      = bus.req0_y;
                vga_colour_d = bus.req0_colour;
                vga_plot_d   = 1'b1;
            end else begin
                vga_plot_d   = 1'b0;
            end
        end else if (grant1_s) begin
            last_grant_d = 1'b1;
            if (in_range(bus.req1_x, bus.req1_y)) begin
                vga_x_d      = bus.req1_x;
                vga_y_d      = bus.req1_y;
                vga_colour_d = bus.req1_colour;
                vga_plot_d   = 1'b1;
            end else begin
                vga_plot_d   = 1'b0;
            end
        end else begin
            vga_plot_d = 1'b0;
        end
    end

    // State, sweep counters and registered vga_adapter drive.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_ARB;
            last_grant_q <= 1'b1;
            cx_q         <= 8'd0;
            cy_q         <= 7'd0;
            clr_colour_q <= 3'd0;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= 3'd0;
            vga_plot_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            clr_colour_q <= clr_colour_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.req0_ready = grant0_s;
    assign bus.req1_ready = grant1_s;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;
    assign bus.clear_busy = busy_q;
    assign bus.clear_done = done_q;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: vector table for arbitration, plus
// hand-written clear-sweep, re-pulse and mid-sweep reset sequences.
module tb_vga_plot_arbiter;
    logic clock;
    logic resetn;
    int   n_cmp;
    int   n_bad;

    vga_plot_arbiter_if bus ();

    vga_plot_arbiter #(.SCREEN_W(160), .SCREEN_H(120)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       v0;
        logic [7:0] x0;
        logic [6:0] y0;
        logic [2:0] c0;
        logic       v1;
        logic [7:0] x1;
        logic [6:0] y1;
        logic [2:0] c1;
        logic       r0;
        logic       r1;
        logic       plot;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_reqs(input logic v0, input logic [7:0] x0, input logic [6:0] y0,
                            input logic [2:0] c0, input logic v1, input logic [7:0] x1,
                            input logic [6:0] y1, input logic [2:0] c1);
        bus.req0_valid = v0; bus.req0_x = x0; bus.req0_y = y0; bus.req0_colour = c0;
        bus.req1_valid = v1; bus.req1_x = x1; bus.req1_y = y1; bus.req1_colour = c1;
    endtask

    // Sweep with both requesters valid; exp_g is the requester expected to win
    // on the cycle of the last clear pixel.
    task automatic run_sweep(input int repulse_at, input logic exp_g, input string tag);
        int   plots, bad_pix, bad_rdy, bad_busy, done_cnt, idle_bad;
        logic done_ok, finished;
        plots = 0; bad_pix = 0; bad_rdy = 0; bad_busy = 0; done_cnt = 0; idle_bad = 0;
        done_ok = 1'b0; finished = 1'b0;
        set_reqs(1'b1, 8'd1, 7'd1, 3'b001, 1'b1, 8'd2, 7'd2, 3'b010);
        bus.clear_start  = 1'b1;
        bus.clear_colour = 3'b011;
        @(negedge clock);
        check({tag, "_start_rdy0"}, {31'd0, bus.req0_ready}, 32'd0);
        check({tag, "_start_rdy1"}, {31'd0, bus.req1_ready}, 32'd0);
        @(posedge clock); #1;
        bus.clear_start  = 1'b0;
        bus.clear_colour = 3'b100;
        for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
            if (!(bus.vga_plot === 1'b1 && bus.vga_x === 8'(plots % 160) &&
                  bus.vga_y === 7'(plots / 160) && bus.vga_colour === 3'b011)) begin
                if (bad_pix == 0)
                    $display("pixel %0d wrong: plot=%0b x=%0d y=%0d c=%0d",
                             plots, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour);
                bad_pix++;
            end
            plots++;
            if (bus.clear_busy !== 1'b1) bad_busy++;
            if (bus.clear_done === 1'b1) begin
                done_cnt++;
                if (plots == 19200) done_ok = 1'b1;
            end
            bus.clear_start = (cyc == repulse_at);
            @(negedge clock);
            if (plots == 19200) begin
                finished = 1'b1;
            end else begin
                if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) bad_rdy++;
                @(posedge clock); #1;
            end
        end
        check({tag, "_bad_pixels"}, bad_pix, 32'd0);
        check({tag, "_plot_count"}, plots, 32'd19200);
        check({tag, "_busy_gaps"}, bad_busy, 32'd0);
        check({tag, "_ready_in_sweep"}, bad_rdy, 32'd0);
        check({tag, "_done_pulses"}, done_cnt, 32'd1);
        check({tag, "_done_on_last"}, {31'd0, done_ok}, 32'd1);
        check({tag, "_end_rdy0"}, {31'd0, bus.req0_ready}, {31'd0, ~exp_g});
        check({tag, "_end_rdy1"}, {31'd0, bus.req1_ready}, {31'd0, exp_g});
        @(posedge clock); #1;
        set_reqs(1'b0, 8'd0, 7'd0, 3'b000, 1'b0, 8'd0, 7'd0, 3'b000);
        bus.clear_start = 1'b0;
        check({tag, "_after_busy"}, {31'd0, bus.clear_busy}, 32'd0);
        check({tag, "_after_done"}, {31'd0, bus.clear_done}, 32'd0);
        check({tag, "_after_plot"}, {31'd0, bus.vga_plot}, 32'd1);
        check({tag, "_after_x"}, {24'd0, bus.vga_x}, exp_g ? 32'd2 : 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            if (bus.vga_plot !== 1'b0 || bus.clear_busy !== 1'b0) idle_bad++;
        end
        check({tag, "_no_second_sweep"}, idle_bad, 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        resetn = 1'b0;
        bus.clear_start  = 1'b0;
        bus.clear_colour = 3'b000;
        set_reqs(1'b0, 8'd0, 7'd0, 3'b000, 1'b0, 8'd0, 7'd0, 3'b000);

        //          v0    x0      y0     c0       v1    x1       y1      c1       r0    r1    plot  ex       ey      ec
        vecs[0]  = '{1'b1, 8'd5,   7'd7,   3'b101, 1'b0, 8'd0,   7'd0,   3'b000, 1'b1, 1'b0, 1'b1, 8'd5,   7'd7,   3'b101};
        vecs[1]  = '{1'b0, 8'd0,   7'd0,   3'b000, 1'b0, 8'd0,   7'd0,   3'b000, 1'b0, 1'b0, 1'b0, 8'd0,   7'd0,   3'b000};
        vecs[2]  = '{1'b0, 8'd0,   7'd0,   3'b000, 1'b1, 8'd9,   7'd4,   3'b110, 1'b0, 1'b1, 1'b1, 8'd9,   7'd4,   3'b110};
        vecs[3]  = '{1'b1, 8'd1,   7'd1,   3'b001, 1'b1, 8'd2,   7'd2,   3'b010, 1'b1, 1'b0, 1'b1, 8'd1,   7'd1,   3'b001};
        vecs[4]  = '{1'b1, 8'd1,   7'd1,   3'b001, 1'b1, 8'd2,   7'd2,   3'b010, 1'b0, 1'b1, 1'b1, 8'd2,   7'd2,   3'b010};
        vecs[5]  = '{1'b1, 8'd1,   7'd1,   3'b001, 1'b1, 8'd2,   7'd2,   3'b010, 1'b1, 1'b0, 1'b1, 8'd1,   7'd1,   3'b001};
        vecs[6]  = '{1'b1, 8'd1,   7'd1,   3'b001, 1'b1, 8'd2,   7'd2,   3'b010, 1'b0, 1'b1, 1'b1, 8'd2,   7'd2,   3'b010};
        vecs[7]  = '{1'b0, 8'd0,   7'd0,   3'b000, 1'b1, 8'd160, 7'd3,   3'b111, 1'b0, 1'b1, 1'b0, 8'd0,   7'd0,   3'b000};
        vecs[8]  = '{1'b1, 8'd3,   7'd3,   3'b111, 1'b1, 8'd4,   7'd4,   3'b001, 1'b1, 1'b0, 1'b1, 8'd3,   7'd3,   3'b111};
        vecs[9]  = '{1'b0, 8'd0,   7'd0,   3'b000, 1'b1, 8'd10,  7'd119, 3'b010, 1'b0, 1'b1, 1'b1, 8'd10,  7'd119, 3'b010};
        vecs[10] = '{1'b1, 8'd159, 7'd0,   3'b011, 1'b0, 8'd0,   7'd0,   3'b000, 1'b1, 1'b0, 1'b1, 8'd159, 7'd0,   3'b011};
        vecs[11] = '{1'b1, 8'd0,   7'd120, 3'b100, 1'b0, 8'd0,   7'd0,   3'b000, 1'b1, 1'b0, 1'b0, 8'd0,   7'd0,   3'b000};
        vecs[12] = '{1'b1, 8'd20,  7'd20,  3'b101, 1'b1, 8'd7,   7'd8,   3'b100, 1'b0, 1'b1, 1'b1, 8'd7,   7'd8,   3'b100};
        vecs[13] = '{1'b0, 8'd0,   7'd0,   3'b000, 1'b0, 8'd0,   7'd0,   3'b000, 1'b0, 1'b0, 1'b0, 8'd0,   7'd0,   3'b000};

        repeat (2) @(posedge clock);
        #1;
        check("rst_vga_x", {24'd0, bus.vga_x}, 32'd0);
        check("rst_vga_y", {25'd0, bus.vga_y}, 32'd0);
        check("rst_colour", {29'd0, bus.vga_colour}, 32'd0);
        check("rst_plot", {31'd0, bus.vga_plot}, 32'd0);
        check("rst_busy", {31'd0, bus.clear_busy}, 32'd0);
        check("rst_done", {31'd0, bus.clear_done}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 14; i++) begin
            set_reqs(vecs[i].v0, vecs[i].x0, vecs[i].y0, vecs[i].c0,
                     vecs[i].v1, vecs[i].x1, vecs[i].y1, vecs[i].c1);
            @(negedge clock);
            check($sformatf("vec%0d_rdy0", i), {31'd0, bus.req0_ready}, {31'd0, vecs[i].r0});
            check($sformatf("vec%0d_rdy1", i), {31'd0, bus.req1_ready}, {31'd0, vecs[i].r1});
            @(posedge clock); #1;
            check($sformatf("vec%0d_plot", i), {31'd0, bus.vga_plot}, {31'd0, vecs[i].plot});
            if (vecs[i].plot) begin
                check($sformatf("vec%0d_x", i), {24'd0, bus.vga_x}, {24'd0, vecs[i].ex});
                check($sformatf("vec%0d_y", i), {25'd0, bus.vga_y}, {25'd0, vecs[i].ey});
                check($sformatf("vec%0d_c", i), {29'd0, bus.vga_colour}, {29'd0, vecs[i].ec});
            end
        end

        // last grant was requester 1, so requester 0 wins at the end of sweep 1
        run_sweep(-1, 1'b0, "sweep1");
        run_sweep(5000, 1'b1, "repulse");

        bus.clear_start  = 1'b1;
        bus.clear_colour = 3'b011;
        @(posedge clock); #1;
        bus.clear_start = 1'b0;
        repeat (499) @(posedge clock);
        #1;
        check("pre_rst_pix500_x", {24'd0, bus.vga_x}, 32'd19);
        check("pre_rst_pix500_y", {25'd0, bus.vga_y}, 32'd3);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_x", {24'd0, bus.vga_x}, 32'd0);
        check("midrst_y", {25'd0, bus.vga_y}, 32'd0);
        check("midrst_colour", {29'd0, bus.vga_colour}, 32'd0);
        check("midrst_plot", {31'd0, bus.vga_plot}, 32'd0);
        check("midrst_busy", {31'd0, bus.clear_busy}, 32'd0);
        check("midrst_done", {31'd0, bus.clear_done}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;
        check("post_rst_busy", {31'd0, bus.clear_busy}, 32'd0);
        check("post_rst_plot", {31'd0, bus.vga_plot}, 32'd0);
        run_sweep(-1, 1'b0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
